// File: rtl/ps2_frame_receiver.sv
`default_nettype none
// =============================================================================
// ps2_frame_receiver : receives PS/2 device-to-host frames and strobes out bytes
// Revision 1.0
// =============================================================================
module ps2_frame_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic [7:0] out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   par_ok_q, par_ok_d;
  logic [7:0]             out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic [7:0]             err_count_q, err_count_d;

  logic clk_s, data_s, fall;

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], PS2_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], PS2_data};
    clk_s        = clk_sync_q[SYNC_STAGES-1];
    data_s       = data_sync_q[SYNC_STAGES-1];
    clk_prev_d   = clk_s;
    fall         = clk_prev_q & ~clk_s;

    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    par_ok_d     = par_ok_q;
    out_d        = out_q;
    valid_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_cnt_d    = (state_q == S_IDLE || fall) ? '0 : tmo_cnt_q + TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        // A fall with data high is a glitch start and is silently ignored
        if (fall && !data_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_ok_d = ^{shreg_q, data_s};
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d      = S_IDLE;
          parity_err_d = ~par_ok_q;
          frame_err_d  = ~data_s;
          if (data_s && par_ok_q) begin
            out_d   = shreg_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-edge timeout abandons the partial frame
    if (state_q != S_IDLE && !fall && tmo_cnt_q == TMO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
      shreg_d     = 8'h00;
    end

    busy_d      = (state_d != S_IDLE);
    err_count_d = ((parity_err_q || frame_err_q) && err_count_q != 8'hFF)
                  ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      shreg_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      tmo_cnt_q    <= '0;
      par_ok_q     <= 1'b0;
      out_q        <= 8'h00;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_count_q  <= 8'h00;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      par_ok_q     <= par_ok_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out        = out_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_receiver.sv
`default_nettype none
// =============================================================================
// tb_ps2_frame_receiver : table-driven and scoreboard bench for ps2_frame_receiver
// Revision 1.0
// =============================================================================
module tb_ps2_frame_receiver;

  localparam int TMO  = 5000;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] out;
  logic       valid, parity_err, frame_err, busy;
  logic [7:0] err_count;

  ps2_frame_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .system_clk (clk),
    .reset      (reset),
    .PS2_clk    (ps2_clk),
    .PS2_data   (ps2_data),
    .out        (out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       pe;
    logic       fe;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic       ev;
    logic       epe;
    logic       efe;
    logic [7:0] exp_out;
    logic [7:0] exp_err;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  got;
  vec_t vec[9];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_ev(input logic v, input logic pe, input logic fe, input logic [7:0] b);
    ev_t e;
    e.v = v; e.pe = pe; e.fe = fe; e.b = b;
    exp_q.push_back(e);
  endtask

  // Drives the first n bits LSB first, data changing while the PS/2 clock is high
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bits({stop, par, d, 1'b0}, 11);
  endtask

  always @(negedge clk) begin
    if (!reset && (valid || parity_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, valid, parity_err, frame_err}, 32'd0);
      end else begin
        got = exp_q.pop_front();
        check("strobe_flags", {29'd0, valid, parity_err, frame_err}, {29'd0, got.v, got.pe, got.fe});
        if (got.v) check("strobe_byte", {24'd0, out}, {24'd0, got.b});
      end
    end
  end

  task automatic check_state(input string tag, input logic [7:0] eo, input logic [7:0] ee);
    check({tag, "_out"},  {24'd0, out}, {24'd0, eo});
    check({tag, "_errc"}, {24'd0, err_count}, {24'd0, ee});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    vec[0] = '{8'h1C, 1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b0, 8'h1C, 8'd0};
    vec[1] = '{8'hF0, 1'b1, 1'b1,  0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'd0};
    vec[2] = '{8'h1C, 1'b0, 1'b1,  0, 1'b1, 1'b0, 1'b0, 8'h1C, 8'd0};
    vec[3] = '{8'h1C, 1'b1, 1'b1,  5, 1'b0, 1'b1, 1'b0, 8'h1C, 8'd1};
    vec[4] = '{8'h5A, 1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b1, 8'h1C, 8'd2};
    vec[5] = '{8'h5A, 1'b1, 1'b1,  5, 1'b1, 1'b0, 1'b0, 8'h5A, 8'd2};
    vec[6] = '{8'h5A, 1'b0, 1'b0,  5, 1'b0, 1'b1, 1'b1, 8'h5A, 8'd3};
    vec[7] = '{8'h00, 1'b1, 1'b1,  5, 1'b1, 1'b0, 1'b0, 8'h00, 8'd3};
    vec[8] = '{8'hFF, 1'b1, 1'b1,  5, 1'b1, 1'b0, 1'b0, 8'hFF, 8'd3};

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out",   {24'd0, out}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_perr",  {31'd0, parity_err}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_errc",  {24'd0, err_count}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      repeat (vec[i].gap) @(negedge clk);
      if (vec[i].ev || vec[i].epe || vec[i].efe)
        push_ev(vec[i].ev, vec[i].epe, vec[i].efe, vec[i].data);
      send_frame(vec[i].data, vec[i].par, vec[i].stop);
      check_state($sformatf("vec%0d", i), vec[i].exp_out, vec[i].exp_err);
    end

    // Timeout: start plus four data bits, then the clock stays high
    push_ev(1'b0, 1'b0, 1'b1, 8'h00);
    send_bits({2'b11, 8'h29, 1'b0}, 5);
    check("tmo_busy_mid", {31'd0, busy}, 32'd1);
    repeat (TMO + 10) @(negedge clk);
    check_state("tmo", 8'hFF, 8'd4);
    push_ev(1'b1, 1'b0, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0, 1'b1);
    check_state("after_tmo", 8'h29, 8'd4);

    // Glitch start: a fall with data high in IDLE
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    check_state("glitch", 8'h29, 8'd4);

    // Reset in the middle of a frame
    send_bits({2'b11, 8'h1C, 1'b0}, 6);
    check("mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_out",   {24'd0, out}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_perr",  {31'd0, parity_err}, 32'd0);
    check("mid_rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_errc",  {24'd0, err_count}, 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    push_ev(1'b1, 1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_state("after_rst", 8'h1C, 8'd0);

    repeat (20) @(negedge clk);
    check("final_pending", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
